// File: rtl/rr_stream_mux_pkg.sv
// ============================================================================
// rr_stream_mux_pkg -- shared constants and helpers for the stream mux
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

package rr_stream_mux_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // A single channel still needs a 1-bit index so ports never collapse to zero width.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_stream_mux_arbiter.sv
// ============================================================================
// rr_arbiter -- rotating-priority / fixed-select arbiter with one-hot grant
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import rr_stream_mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CW   = clog2_min1(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] req,
   input  logic            mode,
   input  logic [CW-1:0]   sel,
   input  logic            advance,
   output logic [N_CH-1:0] grant,
   output logic [CW-1:0]   grant_idx
);

   logic [CW-1:0]   r_ptr;
   logic [N_CH-1:0] w_mask;
   logic [N_CH-1:0] w_pool;
   logic [N_CH-1:0] w_grant;
   logic [CW-1:0]   w_idx;

   // Requests at or above ptr take priority; if none, fall back to the whole
   // vector, which gives the wrap-around search as a lowest-set-bit pick.
   always_comb begin
      w_mask  = '0;
      w_pool  = '0;
      w_grant = '0;
      w_idx   = '0;
      if (mode == MODE_FIXED) begin
         for (int i = 0; i < N_CH; i++) begin
            w_mask[i] = (int'(sel) == i);
         end
         w_pool = req & w_mask;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            w_mask[i] = (i >= int'(r_ptr));
         end
         w_pool = (|(req & w_mask)) ? (req & w_mask) : req;
      end
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (w_pool[i]) begin
            w_grant    = '0;
            w_grant[i] = 1'b1;
            w_idx      = CW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (advance && (mode == MODE_RR)) begin
         r_ptr <= (w_idx == CW'(N_CH - 1)) ? '0 : w_idx + CW'(1);
      end
   end

   assign grant     = w_grant;
   assign grant_idx = w_idx;

endmodule

`default_nettype wire

// File: rtl/rr_stream_mux.sv
// ============================================================================
// rr_stream_mux -- N-channel stream mux with round-robin or fixed selection
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

module rr_stream_mux
   import rr_stream_mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 8,
   parameter int CW   = clog2_min1(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH*W-1:0] in_data,
   input  logic [N_CH-1:0]   in_valid,
   output logic [N_CH-1:0]   in_ready,
   input  logic              mode,
   input  logic [CW-1:0]     sel,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   output logic [CW-1:0]     out_ch,
   input  logic              out_ready
);

   logic [N_CH-1:0] w_grant;
   logic [CW-1:0]   w_idx;
   logic            w_load;
   logic            w_xfer;
   logic [W-1:0]    w_sel_data;

   logic [W-1:0]    r_data;
   logic            r_valid;
   logic [CW-1:0]   r_ch;

   rr_arbiter #(
      .N_CH (N_CH),
      .CW   (CW)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .mode      (mode),
      .sel       (sel),
      .advance   (w_xfer),
      .grant     (w_grant),
      .grant_idx (w_idx)
   );

   // Slot is free when empty or draining this cycle; reset blocks all accepts.
   assign w_load   = !r_valid || out_ready;
   assign in_ready = (w_load && !rst) ? w_grant : '0;
   assign w_xfer   = |(in_valid & in_ready);

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_grant[i]) begin
            w_sel_data = in_data[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ch    <= '0;
      end else if (w_xfer) begin
         r_data  <= w_sel_data;
         r_valid <= 1'b1;
         r_ch    <= w_idx;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign out_ch    = r_ch;

endmodule

`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
// ============================================================================
// tb_rr_stream_mux -- directed self-checking bench for rr_stream_mux
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_stream_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [1:0]  out_ch;
   logic        out_ready;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic        mode3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic [1:0]  out_ch3;
   logic        out_ready3;

   int n_vec = 0;
   int n_err = 0;

   rr_stream_mux #(.N_CH(4), .W(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
   );

   rr_stream_mux #(.N_CH(3), .W(8)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
      .out_valid(out_valid3), .out_ch(out_ch3), .out_ready(out_ready3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
      check({tag, ".valid"}, 64'(out_valid), 64'(v));
      check({tag, ".data"},  64'(out_data),  64'(d));
      check({tag, ".ch"},    64'(out_ch),    64'(c));
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
      in_data = 32'h43322110; in_valid = 4'hF;
      in_data3 = 24'h0; in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;

      // reset state and no accept while reset is held
      tick();
      tick();
      chk_out("reset", 1'b0, 8'h00, 2'd0);
      check("reset.ptr", 64'(dut.u_arb.r_ptr), 64'd0);
      check("reset.in_ready", 64'(in_ready), 64'h0);
      check("reset.in_ready3", 64'(in_ready3), 64'h0);

      // round-robin across all four channels, full throughput
      rst = 1'b0;
      #1;
      check("rr.first_ready", 64'(in_ready), 64'b0001);
      tick(); chk_out("rr0", 1'b1, 8'h10, 2'd0);
      tick(); chk_out("rr1", 1'b1, 8'h21, 2'd1);
      tick(); chk_out("rr2", 1'b1, 8'h32, 2'd2);
      tick(); chk_out("rr3", 1'b1, 8'h43, 2'd3);
      tick(); chk_out("rr4", 1'b1, 8'h10, 2'd0);
      check("rr.ptr", 64'(dut.u_arb.r_ptr), 64'd1);

      // drain: valid falls, data holds
      in_valid = 4'b0000;
      tick(); chk_out("drain", 1'b0, 8'h10, 2'd0);

      // move ptr to 3, then only ch1 requests: wrap-around grant
      in_valid = 4'b0100;
      tick(); chk_out("p3", 1'b1, 8'h32, 2'd2);
      check("p3.ptr", 64'(dut.u_arb.r_ptr), 64'd3);
      in_valid = 4'b0010;
      #1;
      check("wrap.in_ready", 64'(in_ready), 64'b0010);
      tick(); chk_out("wrap", 1'b1, 8'h21, 2'd1);
      check("wrap.ptr", 64'(dut.u_arb.r_ptr), 64'd2);

      // backpressure hold
      in_valid = 4'b0100; in_data[23:16] = 8'hA5;
      tick(); chk_out("bp.load", 1'b1, 8'hA5, 2'd2);
      out_ready = 1'b0; in_data[23:16] = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            mode = 1'b1; sel = 2'd0;
         end
         #1;
         check("bp.in_ready", 64'(in_ready), 64'h0);
         tick(); chk_out("bp.hold", 1'b1, 8'hA5, 2'd2);
      end
      mode = 1'b0;
      out_ready = 1'b1;
      #1;
      check("bp.release_ready", 64'(in_ready), 64'b0100);
      tick(); chk_out("bp.release", 1'b1, 8'h5A, 2'd2);
      in_valid = 4'b0000;
      tick(); chk_out("bp.drain", 1'b0, 8'h5A, 2'd2);

      // fixed select
      mode = 1'b1; sel = 2'd2; in_valid = 4'b0101;
      in_data[7:0] = 8'h10; in_data[23:16] = 8'h77;
      #1;
      check("fix.in_ready", 64'(in_ready), 64'b0100);
      tick(); chk_out("fix0", 1'b1, 8'h77, 2'd2);
      tick(); chk_out("fix1", 1'b1, 8'h77, 2'd2);
      check("fix.ptr", 64'(dut.u_arb.r_ptr), 64'd3);
      sel = 2'd3;
      #1;
      check("fix.idle_ready", 64'(in_ready), 64'h0);
      tick(); chk_out("fix.idle", 1'b0, 8'h77, 2'd2);

      // three-channel instance: sel out of range grants nothing
      mode3 = 1'b1; sel3 = 2'd3;
      #1;
      check("n3.sel3_ready", 64'(in_ready3), 64'h0);
      sel3 = 2'd1;
      #1;
      check("n3.sel1_ready", 64'(in_ready3), 64'b010);

      // reset mid-stream with a word held and ch1 pending
      mode = 1'b0; in_valid = 4'b0010; in_data[15:8] = 8'h21;
      tick(); chk_out("mid.load", 1'b1, 8'h21, 2'd1);
      out_ready = 1'b0; rst = 1'b1;
      #1;
      check("mid.in_ready", 64'(in_ready), 64'h0);
      tick(); chk_out("mid.reset", 1'b0, 8'h00, 2'd0);
      check("mid.ptr", 64'(dut.u_arb.r_ptr), 64'd0);
      rst = 1'b0; out_ready = 1'b1;
      tick(); chk_out("mid.resume", 1'b1, 8'h21, 2'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter N_CH, default 4, number of input channels (legal 1..16).
REQ-002 Parameter W, default 8, data width per channel in bits (legal 1..64).
REQ-003 Parameter CW, default $clog2(N_CH) with minimum 1, channel-index width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  N_CH*W  channel i occupies bits [i*W +: W].
REQ-007 in_valid  input  N_CH  per-channel data-valid.
REQ-008 in_ready  output  N_CH  per-channel accept; combinational.
REQ-009 mode  input  1  0 = round-robin arbitration, 1 = fixed select.
REQ-010 sel  input  CW  channel index used when mode=1.
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_valid  output  1  registered output-valid.
REQ-013 out_ch  output  CW  registered index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Transfer on a channel SHALL occur when in_valid[i] and in_ready[i] are both 1 at a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 load = (!out_valid || out_ready); in_ready[i] SHALL be 1 only when load=1 and channel i holds the grant; at most one in_ready bit SHALL be high per cycle.
REQ-017 Mode 0: the grant SHALL go to the first channel with in_valid=1, searching from ptr upward with wrap from N_CH-1 to 0.
REQ-018 Mode 0: on each input transfer from channel g, ptr SHALL become (g+1) mod N_CH; ptr SHALL NOT change otherwise.
REQ-019 Mode 1: only channel sel SHALL be eligible; if sel >= N_CH, no channel SHALL be granted; ptr SHALL be held.
REQ-020 On an input transfer, out_data, out_ch and out_valid=1 SHALL be registered that edge; latency from input transfer to out_valid is 1 cycle.
REQ-021 With out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold unchanged.
REQ-022 Output transfer with no simultaneous input transfer SHALL clear out_valid next cycle; simultaneous input and output transfer SHALL keep out_valid=1 with new data (full throughput, one word per cycle).
REQ-023 out_data SHALL hold its last value when out_valid falls.
REQ-024 A change of mode or sel SHALL affect only the grant computed in that cycle; a word already registered SHALL be unaffected.
REQ-025 N_CH=1: ptr SHALL stay 0 and the block SHALL behave as a one-stage register slice on channel 0.

Reset
REQ-026 On rst=1 at a rising edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-027 While rst=1, in_ready SHALL be all-zero; no transfer SHALL occur in that cycle.
REQ-028 Reset mid-stream SHALL discard the registered word without an output transfer.

Structure
REQ-029 A shared package SHALL hold the MODE_RR/MODE_FIXED constants and the clog2-with-minimum-1 function.
REQ-030 Arbitration (ptr register plus wrap-around priority search, one-hot grant and index out) SHALL be a sub-module rr_arbiter parametrised by N_CH.
REQ-031 The datapath SHALL be one W-bit register plus one CW-bit index register; no FIFO.

Verification (N_CH=4, W=8)
REQ-032 Mode 0, all four valid, out_ready=1, data 0x10/0x21/0x32/0x43 -> out sequence ch0,1,2,3,0 on consecutive cycles, out_data 0x10,0x21,0x32,0x43,0x10.
REQ-033 Mode 0, ptr=3, only ch1 valid -> ch1 granted (wrap), next ptr=2.
REQ-034 out_ready=0 for 3 cycles with ch2 valid (0xA5) -> out_valid=1, out_data=0xA5 held, in_ready all-zero; release -> transfer, then next grant.
REQ-035 Mode 1, sel=2, ch0 and ch2 valid -> only ch2 serviced; sel=3 with ch3 idle -> no output; with N_CH=3 and sel=3 -> in_ready all-zero.
REQ-036 rst asserted with out_valid=1 and ch1 valid -> next cycle out_valid=0, out_data=0, ptr=0, and ch1 not acknowledged in the reset cycle.
